// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM state encodings and requester ids.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// One requester port of the SRAM arbiter; master = requester side, slave = arbiter side.
interface sram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          done;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, done, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, done, rdata);

endinterface

// File: rtl/sram_arb_sel.sv
// Combinational winner select between ports A and B.
// SRAM_ARB_RR_EN selects round-robin on ties; otherwise port B always wins a tie.
module sram_arb_sel
  import sram_arb_pkg::*;
(
  input  logic   a_req,
  input  logic   b_req,
`ifdef SRAM_ARB_RR_EN
  input  owner_e rr_ptr,
`endif
  output logic   valid,
  output owner_e winner
);

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    valid  = a_req | b_req;
    winner = OWN_A;
`ifdef SRAM_ARB_RR_EN
    if (a_req && b_req) begin
      winner = rr_ptr;
    end else if (b_req) begin
      winner = OWN_B;
    end
`else
    if (b_req) begin
      winner = OWN_B;
    end
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for an asynchronous SRAM; sequences SETUP/ACCESS/HOLD with registered strobes.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking (default: port B wins ties).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave a,
  sram_arbiter_if.slave b,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data,
  output logic          ram_ce_l,
  output logic          ram_oe_l,
  output logic          ram_we_l
);

  localparam int CW = $clog2(ACCESS_CYCLES) + 1;

  state_e        state;
  owner_e        owner;
  logic          we_r;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dout;
  logic [DW-1:0] rbuf;
  logic          drive_en;

  logic          sel_valid;
  owner_e        sel_owner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef SRAM_ARB_RR_EN
  owner_e        rr_ptr;
`endif

  sram_arb_sel u_sel (
    .a_req  (a.req),
    .b_req  (b.req),
`ifdef SRAM_ARB_RR_EN
    .rr_ptr (rr_ptr),
`endif
    .valid  (sel_valid),
    .winner (sel_owner)
  );

  always_comb begin
    sel_we    = a.we;
    sel_addr  = a.addr;
    sel_wdata = a.wdata;
    if (sel_owner == OWN_B) begin
      sel_we    = b.we;
      sel_addr  = b.addr;
      sel_wdata = b.wdata;
    end
  end

  // Bus enable comes from a flop, so the data pins only change on clock edges or reset.
  assign ram_data = drive_en ? dout : {DW{1'bz}};

  // NOTE: sequential state uses non-blocking assignments only; each pin is a flop,
  // so the outputs for a state are loaded on the edge that enters it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= OWN_A;
      we_r     <= 1'b0;
      cnt      <= '0;
      dout     <= '0;
      rbuf     <= '0;
      drive_en <= 1'b0;
      ram_addr <= '0;
      ram_ce_l <= 1'b1;
      ram_oe_l <= 1'b1;
      ram_we_l <= 1'b1;
      a.gnt    <= 1'b0;
      a.done   <= 1'b0;
      a.rdata  <= '0;
      b.gnt    <= 1'b0;
      b.done   <= 1'b0;
      b.rdata  <= '0;
`ifdef SRAM_ARB_RR_EN
      rr_ptr   <= OWN_A;
`endif
    end else begin
      a.gnt  <= 1'b0;
      b.gnt  <= 1'b0;
      a.done <= 1'b0;
      b.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            owner    <= sel_owner;
            we_r     <= sel_we;
            ram_addr <= sel_addr;
            dout     <= sel_wdata;
            drive_en <= sel_we;
            ram_ce_l <= 1'b0;
            ram_oe_l <= sel_we;
            if (sel_owner == OWN_A) a.gnt <= 1'b1;
            else                    b.gnt <= 1'b1;
`ifdef SRAM_ARB_RR_EN
            rr_ptr   <= (sel_owner == OWN_A) ? OWN_B : OWN_A;
`endif
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          ram_we_l <= ~we_r;
          cnt      <= '0;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (cnt == CW'(ACCESS_CYCLES - 1)) begin
            // Read data is taken while OE is still low, before the strobe lifts.
            if (!we_r) rbuf <= ram_data;
            ram_we_l <= 1'b1;
            ram_oe_l <= 1'b1;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          ram_ce_l <= 1'b1;
          drive_en <= 1'b0;
          if (owner == OWN_A) begin
            a.done <= 1'b1;
            if (!we_r) a.rdata <= rbuf;
          end else begin
            b.done <= 1'b1;
            if (!we_r) b.rdata <= rbuf;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random two-port traffic,
// all judged by a cycle-level reference model of the access protocol and arbitration rule.
module tb_sram_arbiter;

  parameter int ACC = 2;

  logic        clk;
  logic        rst;
  logic [15:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_ce_l;
  logic        ram_oe_l;
  logic        ram_we_l;
  int          cyc;
  int          n_tests;
  int          n_fail;

  sram_arbiter_if #(.AW(16), .DW(16)) ia ();
  sram_arbiter_if #(.AW(16), .DW(16)) ib ();

  sram_arbiter #(.AW(16), .DW(16), .ACCESS_CYCLES(ACC)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (ia.slave),
    .b        (ib.slave),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_ce_l (ram_ce_l),
    .ram_oe_l (ram_oe_l),
    .ram_we_l (ram_we_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM: drives on CE&OE, latches on the rising edge of WE.
  logic [15:0] sram_mem [0:65535];
  assign ram_data = (!ram_ce_l && !ram_oe_l && ram_we_l) ? sram_mem[ram_addr] : 16'bz;
  always @(posedge ram_we_l) if (!ram_ce_l) sram_mem[ram_addr] = ram_data;

  function automatic logic [15:0] pre(input int adr);
    return 16'((adr * 40503) ^ 23130);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input bit p, input bit r, input bit we, input logic [15:0] adr, input logic [15:0] wd);
    if (p) begin
      ib.req = r; ib.we = we; ib.addr = adr; ib.wdata = wd;
    end else begin
      ia.req = r; ia.we = we; ia.addr = adr; ia.wdata = wd;
    end
  endtask

  function automatic bit gnt_of(input bit p);
    return p ? ib.gnt : ia.gnt;
  endfunction
  function automatic bit done_of(input bit p);
    return p ? ib.done : ia.done;
  endfunction
  function automatic logic [15:0] rdata_of(input bit p);
    return p ? ib.rdata : ia.rdata;
  endfunction

  // One requester transaction. drop_after=0 holds req until done; k>0 lowers req after k cycles.
  task automatic access(input bit p, input bit we, input logic [15:0] adr, input logic [15:0] wd,
                        input int drop_after, input bit keep,
                        output bit granted, output logic [15:0] rd, output int lat);
    int  start;
    bit  timed_out;
    bit  active;
    set_req(p, 1'b1, we, adr, wd);
    start = cyc; granted = 1'b0; rd = '0; lat = -1; timed_out = 1'b1; active = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (gnt_of(p)) granted = 1'b1;
      if (done_of(p)) begin
        rd  = rdata_of(p);
        lat = cyc - start;
        if (!keep) set_req(p, 1'b0, we, adr, wd);
        timed_out = 1'b0;
        break;
      end
      if (drop_after > 0 && i >= drop_after && active) begin
        set_req(p, 1'b0, we, adr, wd);
        active = 1'b0;
        if (!granted) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
    check(p ? "b_timeout" : "a_timeout", timed_out, 1'b0);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        rst;
    logic        a_req, b_req, a_we, b_we;
    logic [15:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_done, b_done;
    logic [15:0] a_rdata, b_rdata;
    logic        ce, oe, we;
    logic [15:0] addr, data;
  } smp_t;

  smp_t        p;
  logic [15:0] mmem    [0:65535];
  bit          mmem_ok [0:65535];
  logic [15:0] exp_rd  [2];
  bit          busy;
  int          g_cyc;
  bit          own;
  bit          cur_we;
  logic [15:0] cur_addr, cur_wdata;
  bit          rr_pref;
  bit          gnt_log [$];

  function automatic smp_t capture();
    smp_t s;
    s.rst = rst;
    s.a_req = ia.req; s.a_we = ia.we; s.a_addr = ia.addr; s.a_wdata = ia.wdata;
    s.b_req = ib.req; s.b_we = ib.we; s.b_addr = ib.addr; s.b_wdata = ib.wdata;
    s.a_gnt = ia.gnt; s.a_done = ia.done; s.a_rdata = ia.rdata;
    s.b_gnt = ib.gnt; s.b_done = ib.done; s.b_rdata = ib.rdata;
    s.ce = ram_ce_l; s.oe = ram_oe_l; s.we = ram_we_l; s.addr = ram_addr; s.data = ram_data;
    return s;
  endfunction

  task automatic mon_step(input smp_t s);
    int          win;
    int          ph;
    bit          dn;
    logic [2:0]  pins;
    logic [15:0] zz;
    zz = 16'bz;
    if (s.rst) begin
      if (busy && cur_we) mmem_ok[cur_addr] = 1'b0;
      busy = 1'b0; rr_pref = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
      check("rst_pins", {s.ce, s.oe, s.we}, 3'b111);
      check("rst_bus", s.data, zz);
      check("rst_pulses", {s.a_gnt, s.b_gnt, s.a_done, s.b_done}, 4'b0000);
      check("rst_rdata", {s.a_rdata, s.b_rdata}, 32'h0);
      return;
    end
    win = -1;
    if (!p.rst && !busy && (p.a_req || p.b_req)) begin
      if (p.a_req && p.b_req) begin
`ifdef SRAM_ARB_RR_EN
        win = int'(rr_pref);
`else
        win = 1;
`endif
      end else begin
        win = p.b_req ? 1 : 0;
      end
    end
    if (win >= 0 || s.a_gnt) check("a_gnt", s.a_gnt, win == 0);
    if (win >= 0 || s.b_gnt) check("b_gnt", s.b_gnt, win == 1);
    if (win >= 0) begin
      busy      = 1'b1;
      g_cyc     = cyc;
      own       = bit'(win);
      cur_we    = own ? p.b_we    : p.a_we;
      cur_addr  = own ? p.b_addr  : p.a_addr;
      cur_wdata = own ? p.b_wdata : p.a_wdata;
      rr_pref   = (win == 0);
      gnt_log.push_back(own);
    end
    ph = cyc - g_cyc;
    if (busy && ph <= ACC + 1) begin
      pins[2] = 1'b0;
      pins[1] = !(!cur_we && ph <= ACC);
      pins[0] = !(cur_we && ph >= 1 && ph <= ACC);
      check("pins", {s.ce, s.oe, s.we}, pins);
      check("addr", s.addr, cur_addr);
      if (cur_we)          check("wbus", s.data, cur_wdata);
      else if (ph > ACC)   check("rbus_hold", s.data, zz);
    end else begin
      check("idle_pins", {s.ce, s.oe, s.we}, 3'b111);
      check("idle_bus", s.data, zz);
    end
    dn = busy && ph == ACC + 2;
    if ((dn && !own) || s.a_done) check("a_done", s.a_done, dn && !own);
    if ((dn &&  own) || s.b_done) check("b_done", s.b_done, dn && own);
    if (dn) begin
      if (cur_we) begin
        mmem[cur_addr]    = cur_wdata;
        mmem_ok[cur_addr] = 1'b1;
      end else if (mmem_ok[cur_addr]) begin
        exp_rd[own] = mmem[cur_addr];
      end
      check("a_rdata", s.a_rdata, exp_rd[0]);
      check("b_rdata", s.b_rdata, exp_rd[1]);
      busy = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    #2;
    mon_step(capture());
    p = capture();
  end

  // ---------------- stimulus ----------------
  task automatic rand_port(input bit pt, input int n);
    bit          g;
    logic [15:0] rd;
    int          lat;
    int          da;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      da = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      access(pt, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom), da, 1'b0, g, rd, lat);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    bit          g, g2;
    logic [15:0] rd, rd2;
    int          lat, lat2;
    int          cnt_done;
    bit          exp_order [3];
    logic [15:0] zz;

    zz = 16'bz;
    n_tests = 0; n_fail = 0; cyc = 0;
    busy = 1'b0; rr_pref = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
    p.rst = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = pre(i);
      mmem[i]     = pre(i);
      mmem_ok[i]  = 1'b1;
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_gnt_done", {ia.gnt, ib.gnt, ia.done, ib.done}, 4'b0000);
    check("reset_rdata", {ia.rdata, ib.rdata}, 32'h0);
    check("reset_strobes", {ram_ce_l, ram_oe_l, ram_we_l}, 3'b111);
    check("reset_addr", ram_addr, 16'h0000);
    check("reset_bus", ram_data, zz);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: lone write from A
    access(1'b0, 1'b1, 16'h0012, 16'hBEEF, 0, 1'b0, g, rd, lat);
    check("t1_granted", g, 1'b1);
    check("t1_latency", lat, ACC + 3);
    check("t1_sram", sram_mem[16'h0012], 16'hBEEF);
    tick();

    // 2: read it back
    access(1'b0, 1'b0, 16'h0012, 16'h0000, 0, 1'b0, g, rd, lat);
    check("t2_rdata", rd, 16'hBEEF);
    check("t2_latency", lat, ACC + 3);

    // 3: simultaneous requests from a fresh rr pointer
    pulse_reset();
    gnt_log.delete();
    fork
      begin
        access(1'b0, 1'b0, 16'h0012, 16'h0000, 0, 1'b0, g, rd, lat);
        access(1'b0, 1'b0, 16'h0020, 16'h0000, 0, 1'b0, g2, rd2, lat2);
      end
      begin
        bit          gb;
        logic [15:0] rdb;
        int          latb;
        access(1'b1, 1'b1, 16'h0020, 16'h1234, 0, 1'b0, gb, rdb, latb);
      end
    join
`ifdef SRAM_ARB_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b0, 1'b0};
`endif
    check("t3_grants", gnt_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < gnt_log.size()) check($sformatf("t3_order%0d", i), gnt_log[i], exp_order[i]);
    check("t3_a_second_read", rd2, 16'h1234);

    // 4: reset in the middle of a write
    tick();
    set_req(1'b0, 1'b1, 1'b1, 16'h0040, 16'hCAFE);
    tick();
    tick();
    tick();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b1, 16'h0040, 16'hCAFE);
    #1;
    check("t4_strobes", {ram_ce_l, ram_oe_l, ram_we_l}, 3'b111);
    check("t4_bus", ram_data, zz);
    tick();
    rst = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ia.done) cnt_done++;
    end
    check("t4_no_done", cnt_done, 0);
    access(1'b0, 1'b1, 16'h0040, 16'hCAFE, 0, 1'b0, g, rd, lat);
    check("t4_reissue_latency", lat, ACC + 3);
    access(1'b0, 1'b0, 16'h0040, 16'h0000, 0, 1'b0, g, rd, lat);
    check("t4_readback", rd, 16'hCAFE);

    // 5: B streams three reads with req held high
    for (int i = 1; i <= 3; i++) begin
      access(1'b1, 1'b0, 16'(i), 16'h0000, 0, i < 3, g, rd, lat);
      check($sformatf("t5_rdata%0d", i), rd, pre(i));
      check($sformatf("t5_latency%0d", i), lat, ACC + 3);
    end

    // 6: one-cycle A pulse while B is busy
    tick();
    fork
      begin
        bit          gb;
        logic [15:0] rdb;
        int          latb;
        access(1'b1, 1'b0, 16'h0005, 16'h0000, 0, 1'b0, gb, rdb, latb);
        check("t6_b_rdata", rdb, pre(5));
      end
      begin
        tick();
        tick();
        access(1'b0, 1'b1, 16'h0006, 16'hDEAD, 1, 1'b0, g, rd, lat);
        check("t6_a_not_granted", g, 1'b0);
      end
    join
    repeat (4) tick();
    check("t6_sram_untouched", sram_mem[16'h0006], pre(6));

    // random two-port traffic
    fork
      rand_port(1'b0, 60);
      rand_port(1'b1, 60);
    join
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
